// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
//   Shared types and helpers for adder_arbiter and its arbiter sub-module.
//   - state_e  : output-stage state (EMPTY / FULL)
//   - id_width : width of a requester index for a given requester count
package adder_arbiter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// adder
//   Plain ripple-carry adder, no carry-in.
//   Ports:
//     in1_i, in2_i [Width]  operands
//     sum_o        [Width]  (in1_i + in2_i) mod 2^Width
//     carry_o               bit Width of the full sum
module adder #(
    parameter int Width = 8
) (
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    logic [Width:0] carry;

    always_comb begin
        carry = '0;
        sum_o = '0;
        for (int b = 0; b < Width; b++) begin
            sum_o[b]     = in1_i[b] ^ in2_i[b] ^ carry[b];
            carry[b + 1] = (in1_i[b] & in2_i[b]) | (carry[b] & (in1_i[b] ^ in2_i[b]));
        end
    end

    assign carry_o = carry[Width];

endmodule

// File: rtl/adder_arbiter_rr_arb.sv
// rr_arb
//   Combinational one-hot arbiter.
//   Build option ADDER_ARBITER_RR_EN:
//     defined   : round-robin, scan upward from ptr_i with wrap, first valid wins
//     undefined : fixed priority, lowest valid index wins (ptr_i ignored)
//   Ports:
//     req_i   [NumReq]  request vector
//     ptr_i   [IdW]     round-robin start index
//     grant_o [NumReq]  one-hot grant (all zero when no request)
//     idx_o   [IdW]     encoded grant index (0 when no request)
module rr_arb
    import adder_arbiter_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdW    = id_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdW-1:0]    idx_o
);

`ifdef ADDER_ARBITER_RR_EN
    int             cand;
    logic [IdW-1:0] cand_idx;

    // Walk offsets from the far end back to the pointer so the closest
    // valid requester (smallest offset) is the last one written and wins.
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = IdW'(cand);
            if (req_i[cand_idx]) begin
                grant_o           = '0;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Downward scan: the lowest valid index is written last and wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                grant_o    = '0;
                grant_o[k] = 1'b1;
                idx_o      = IdW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one ripple adder between NumReq requesters. One request is granted
//   per cycle; its sum, carry-out and requester index go into a single-entry
//   output register with its own valid/ready handshake.
//   Build option ADDER_ARBITER_RR_EN selects round-robin arbitration
//   (default, undefined: fixed priority, lowest index wins).
//
//   Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both high. A source holds valid and its data stable
//   until the transfer and never lets valid depend on ready; ready may depend
//   on valid. req_ready_o may depend combinationally on rsp_ready_i.
//
//   Ports:
//     clk_i, rst_i             clock, asynchronous active-high reset
//     req_valid_i/req_ready_o  per-requester handshake (at most one ready high)
//     req_in1_i, req_in2_i     per-requester operands
//     rsp_valid_o/rsp_ready_i  result handshake
//     rsp_sum_o, rsp_carry_o   registered sum and carry-out
//     rsp_id_o                 index of the requester that produced the result
//     dbg_state_o              output-stage state, for observation only
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int Width  = 8,
    parameter int NumReq = 4,
    parameter int IdW    = id_width(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq-1:0][Width-1:0] req_in1_i,
    input  logic [NumReq-1:0][Width-1:0] req_in2_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [Width-1:0]             rsp_sum_o,
    output logic                         rsp_carry_o,
    output logic [IdW-1:0]               rsp_id_o,
    output state_e                       dbg_state_o
);

    state_e            state_q, state_d;
    logic [NumReq-1:0] grant;
    logic [IdW-1:0]    grant_idx;
    logic [IdW-1:0]    ptr;
    logic              space;
    logic              accept;
    logic [Width-1:0]  add_in1, add_in2, add_sum;
    logic              add_carry;
    logic [Width-1:0]  sum_q;
    logic              carry_q;
    logic [IdW-1:0]    id_q;

    rr_arb #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign space       = (state_q == EMPTY) || rsp_ready_i;
    // Reset gating keeps requesters from seeing a handshake while state is forced.
    assign req_ready_o = rst_i ? '0 : (grant & {NumReq{space}});
    assign accept      = |(req_valid_i & req_ready_o);

    assign add_in1 = req_in1_i[grant_idx];
    assign add_in2 = req_in2_i[grant_idx];

    adder #(
        .Width (Width)
    ) u_adder (
        .in1_i   (add_in1),
        .in2_i   (add_in2),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

`ifdef ADDER_ARBITER_RR_EN
    logic [IdW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (grant_idx == IdW'(NumReq - 1)) ? '0 : grant_idx + IdW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rsp_ready_i) begin
                    state_d = accept ? FULL : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            // accept is only possible when the stage has space, so loading
            // here never overwrites a result that has not been taken.
            if (accept) begin
                sum_q   <= add_sum;
                carry_q <= add_carry;
                id_q    <= grant_idx;
            end
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_sum_o   = sum_q;
    assign rsp_carry_o = carry_q;
    assign rsp_id_o    = id_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Directed test for adder_arbiter (Width 8, NumReq 4). Expected results are
//   queued when stimulus is issued; a monitor pops and compares on every
//   result handshake. Arbitration expectations follow ADDER_ARBITER_RR_EN.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int Width  = 8;
    localparam int NumReq = 4;
    localparam int IdW    = 2;
    localparam int EW     = Width + 1 + IdW;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NumReq-1:0]            req_valid;
    logic [NumReq-1:0]            req_ready_o;
    logic [NumReq-1:0][Width-1:0] req_in1;
    logic [NumReq-1:0][Width-1:0] req_in2;
    logic                         rsp_valid_o;
    logic                         rsp_ready;
    logic [Width-1:0]             rsp_sum_o;
    logic                         rsp_carry_o;
    logic [IdW-1:0]               rsp_id_o;
    state_e                       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    adder_arbiter #(
        .Width  (Width),
        .NumReq (NumReq),
        .IdW    (IdW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .req_in1_i   (req_in1),
        .req_in2_i   (req_in2),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready),
        .rsp_sum_o   (rsp_sum_o),
        .rsp_carry_o (rsp_carry_o),
        .rsp_id_o    (rsp_id_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic [7:0] s, input logic c, input logic [1:0] id);
        return {s, c, id};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rsp_valid_o && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got sum 0x%0h id %0d, expected no result", rsp_sum_o, rsp_id_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_sum", rsp_sum_o, mon_exp[EW-1:3]);
                check("rsp_carry", rsp_carry_o, mon_exp[2]);
                check("rsp_id", rsp_id_o, mon_exp[1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drain();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // One request from requester i; expected result given by hand.
    task automatic single(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] es, input logic ec);
        int n;
        @(posedge clk);
        #1;
        exp_q.push_back(pack(es, ec, IdW'(i)));
        req_in1[i]   = a;
        req_in2[i]   = b;
        req_valid[i] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready_o[i] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("single_ready", req_ready_o[i], 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        @(negedge clk);
        check("single_latency", rsp_valid_o, 1);
    endtask

    // Raise several requesters at once; each drops valid after its accept.
    task automatic multi(input logic [3:0] mask);
        logic [3:0] acc;
        int n;
        req_valid = mask;
        n = 0;
        while (req_valid != 4'b0000 && n < 20) begin
            @(negedge clk);
            check("ready_onehot", ($countones(req_ready_o) <= 1), 1);
            acc = req_valid & req_ready_o;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            n++;
        end
        check("multi_done", req_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] sum_tab [4];
    logic [1:0] id_tab  [5];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = 1'b0;

        // Reset state, with every requester asking.
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        check("reset_valid", rsp_valid_o, 0);
        check("reset_sum", rsp_sum_o, 0);
        check("reset_carry", rsp_carry_o, 0);
        check("reset_id", rsp_id_o, 0);
        check("reset_ready", req_ready_o, 0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;

        // Basic arithmetic.
        single(0, 8'h0F, 8'h01, 8'h10, 1'b0);
        single(2, 8'hFF, 8'h01, 8'h00, 1'b1);
        single(2, 8'h80, 8'h80, 8'h00, 1'b1);
        single(1, 8'h12, 8'h34, 8'h46, 1'b0);
        single(3, 8'hF0, 8'h20, 8'h10, 1'b1);

        // All four requesters valid for five accepts.
        sum_tab = '{8'h01, 8'h12, 8'h23, 8'h34};
`ifdef ADDER_ARBITER_RR_EN
        id_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        id_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        @(posedge clk);
        #1;
        req_in1 = {8'h31, 8'h21, 8'h11, 8'h01};
        req_in2 = {8'h03, 8'h02, 8'h01, 8'h00};
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(pack(sum_tab[id_tab[k]], 1'b0, id_tab[k]));
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("all_ready_onehot", ($countones(req_ready_o) == 1), 1);
            @(posedge clk);
        end
        #1;
        req_valid = '0;

        // Pointer wrap: last accept from id 3, then 1 and 2 compete.
        single(3, 8'h40, 8'h41, 8'h81, 1'b0);
        @(posedge clk);
        #1;
        req_in1[1] = 8'h7F;
        req_in2[1] = 8'h01;
        req_in1[2] = 8'hC0;
        req_in2[2] = 8'h50;
        exp_q.push_back(pack(8'h80, 1'b0, 2'd1));
        exp_q.push_back(pack(8'h10, 1'b1, 2'd2));
        multi(4'b0110);

        // Backpressure.
        drain();
        rsp_ready  = 1'b0;
        req_in1[0] = 8'h05;
        req_in2[0] = 8'h06;
        req_valid  = 4'b0001;
        exp_q.push_back(pack(8'h0B, 1'b0, 2'd0));
        exp_q.push_back(pack(8'h42, 1'b0, 2'd1));
        @(negedge clk);
        check("bp_first_ready", req_ready_o, 4'b0001);
        @(posedge clk);
        #1;
        req_in1[1] = 8'h20;
        req_in2[1] = 8'h22;
        req_valid  = 4'b0010;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", rsp_valid_o, 1);
            check("bp_sum", rsp_sum_o, 8'h0B);
            check("bp_carry", rsp_carry_o, 0);
            check("bp_id", rsp_id_o, 0);
            check("bp_ready", req_ready_o, 0);
            check("bp_state", dbg_state, FULL);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", req_ready_o, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("bp_next_valid", rsp_valid_o, 1);

        // Reset while FULL with requests pending; held result is discarded.
        drain();
        rsp_ready  = 1'b0;
        req_in1[2] = 8'h01;
        req_in2[2] = 8'h01;
        req_valid  = 4'b0100;
        @(posedge clk);
        #1;
        req_in1[0] = 8'h33;
        req_in2[0] = 8'h44;
        req_in1[3] = 8'hAA;
        req_in2[3] = 8'h55;
        req_valid  = 4'b1001;
        @(negedge clk);
        check("rst_pre_full", rsp_valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", rsp_valid_o, 0);
        check("rst_async_sum", rsp_sum_o, 0);
        check("rst_ready", req_ready_o, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_ready", req_ready_o, 0);
        check("rst_hold_valid", rsp_valid_o, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        exp_q.push_back(pack(8'h77, 1'b0, 2'd0));
        exp_q.push_back(pack(8'hFF, 1'b0, 2'd3));
        multi(4'b1001);

        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one instance of the team's `adder` ripple adder between `NumReq` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and registers the sum, carry-out and requester ID into a single-entry output stage with its own valid/ready handshake. It sits between client blocks that need occasional additions and a single area-cheap adder instance.

## Interface
- `Width`, 8: operand and sum width, passed to `adder`.
- `NumReq`, 4: number of requesters, >= 2, need not be a power of two.
- `IdW`, derived as `$clog2(NumReq)`: width of the requester ID.

- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  [NumReq]  per-requester request valid.
- `req_ready_o`  out  [NumReq]  per-requester accept; at most one bit high.
- `req_in1_i`  in  [NumReq][Width]  first operand per requester.
- `req_in2_i`  in  [NumReq][Width]  second operand per requester.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  downstream accepts the result.
- `rsp_sum_o`  out  [Width]  registered sum.
- `rsp_carry_o`  out  1  registered carry-out.
- `rsp_id_o`  out  [IdW]  index of the requester whose operands produced this result.

## Operation
- Grant is combinational: a one-hot choice among asserted `req_valid_i` bits, chosen by the arbitration policy described under Configuration.
- The output stage can take a new result when `space = !rsp_valid_o || rsp_ready_i`.
- `req_ready_o[i] = grant[i] & space`.
- A request is accepted when `req_valid_i[i] & req_ready_o[i]`.
- The granted operands are muxed into `adder`.
- On accept, `adder` sum, carry and the granted index are registered.
- Arithmetic: `rsp_sum_o = (in1 + in2) mod 2^Width`; `rsp_carry_o` = bit `Width` of the full sum; there is no carry-in.
- Requesters hold valid and operands stable until accepted; valid must not depend on ready.
- The grant may move between requesters while the output is stalled. Only an accepted request is consumed.
- FSM states:
  - EMPTY: `rsp_valid_o = 0`.
  - FULL: `rsp_valid_o = 1`.
- FSM transitions:
  - EMPTY + accept -> FULL.
  - FULL + `rsp_ready_i` + accept -> FULL, with the new result loaded (back-to-back).
  - FULL + `rsp_ready_i` + no accept -> EMPTY.
  - FULL + `!rsp_ready_i` -> FULL; `rsp_*` outputs held bit-stable; all `req_ready_o` = 0.
- Reset values: state EMPTY; `rsp_valid_o` 0; `rsp_sum_o` 0; `rsp_carry_o` 0; `rsp_id_o` 0; round-robin pointer 0.
- While `rst_i` is high, `req_ready_o` is all 0.
- Reset asserted mid-operation: takes effect immediately (asynchronous). Any held result is discarded and is never presented.

## Timing
- Latency: a request accepted in cycle N gives `rsp_valid_o` = 1 in cycle N+1.
- Throughput: one result per cycle while `rsp_ready_i` = 1.
- No combinational path from `req_*` to `rsp_*`.
- A combinational path from `rsp_ready_i` to `req_ready_o` is permitted.
- Round-robin pointer update: after accepting requester i, the pointer becomes `(i+1) mod NumReq`, wrapping from `NumReq-1` to 0.
- The pointer is unchanged in cycles with no accept.
- Round-robin search: start at the pointer and scan upward with wrap; the first valid requester wins.

## Configuration
- Macro: `ADDER_ARBITER_RR_EN`.
- Defined: round-robin arbitration as described above; starvation-free, each waiting requester is served within `NumReq` accepts.
- Undefined: fixed priority, lowest valid index wins; the pointer register is not built.
- Everything else is identical in both builds.

## Structure
- `adder_arbiter_pkg` holds:
  - the FSM state enum (`EMPTY`, `FULL`);
  - a function returning the ID width for a given `NumReq`.
- Sub-module `rr_arb`:
  - inputs: request vector and pointer;
  - outputs: one-hot grant and encoded index;
  - also contains the fixed-priority path selected by the macro.
- The top level holds the operand mux, the single `adder` instance and the output register/FSM.

## Test plan
- Req 0 only, `in1` = 0x0F, `in2` = 0x01, `rsp_ready_i` = 1 -> next cycle `rsp_valid_o` = 1, sum 0x10, carry 0, id 0.
- Req 2, 0xFF + 0x01 -> sum 0x00, carry 1, id 2; 0x80 + 0x80 -> sum 0x00, carry 1.
- All four requesters valid continuously, `rsp_ready_i` = 1:
  - with `ADDER_ARBITER_RR_EN`: ids 0,1,2,3,0 on consecutive cycles;
  - without the macro: ids 0,0,0,...
- Backpressure: `rsp_ready_i` = 0 for 3 cycles while FULL -> `rsp_*` stable and `req_ready_o` = 0. When `rsp_ready_i` rises, a pending request is accepted in that same cycle and its result appears the next cycle.
- Pointer wrap: last accept from id 3, then requesters 1 and 2 valid -> id 1 granted, then id 2.
- Reset while FULL with requests pending:
  - `rsp_valid_o` drops to 0 asynchronously; `req_ready_o` = 0 during reset;
  - after release, requesters 3 and 0 valid -> id 0 granted first.
